myfunc_sweeper: RTL and testbench

Sequential stimulus-and-check engine for the 4-input `myfunc` truth-table primitive. It drives all 16 input combinations in ascending order onto a function-under-test, waits a programmable settle time, samples the returned output and compares it against a golden truth table. It reports the mismatch count, the first failing vector and an overall pass flag. It sits on the opposite side of the myfunc interface from the primitive: it generates A/B/C/D and receives F.

---
 rtl/myfunc_sweeper.sv | 152 +++++++++++++++
 tb/tb_myfunc_sweeper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/myfunc_sweeper.sv
// myfunc_sweeper: sweeps all 16 {A,B,C,D} vectors onto a myfunc
// function-under-test, waits SETTLE cycles per vector, samples F and
// checks it against a golden truth table.
//
// Optional feature macro: MYFUNC_SWEEP_STOP_ON_FAIL_EN
//   defined   -> the first mismatch ends the sweep immediately
//   undefined -> full 16-vector sweep, every mismatch counted
//
// Parameters:
//   SETTLE   - cycles vec_out is held before the check cycle (1..15)
//   EXPECTED - golden truth table, bit i = expected F for {A,B,C,D}=i
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous active-high reset
//   start          - request a sweep (honoured in IDLE/DONE only)
//   f_in           - F returned by the function-under-test
//   vec_out        - {A,B,C,D} driven to the function-under-test
//   busy           - sweep in progress
//   done           - sweep finished, held until the next accepted start
//   pass           - combinational: done with zero mismatches
//   err_count      - mismatch count (0..16)
//   first_fail     - index of the first mismatching vector
//   first_fail_vld - first_fail holds a valid index
module myfunc_sweeper #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hF051
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  output logic [3:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       first_fail_vld
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       vec_next;
  logic             busy_next, done_next;
  logic [4:0]       err_next;
  logic [3:0]       ff_next;
  logic             ffv_next;
  logic             mismatch;
  logic             stop_now;

  // Compare returned F against the golden table entry for the current vector
  assign mismatch = (f_in != EXPECTED[vec_out]);

`ifdef MYFUNC_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign pass = done & (err_count == 5'd0);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      vec_out        <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= 5'd0;
      first_fail     <= 4'd0;
      first_fail_vld <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      vec_out        <= vec_next;
      busy           <= busy_next;
      done           <= done_next;
      err_count      <= err_next;
      first_fail     <= ff_next;
      first_fail_vld <= ffv_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    vec_next   = vec_out;
    busy_next  = busy;
    done_next  = done;
    err_next   = err_count;
    ff_next    = first_fail;
    ffv_next   = first_fail_vld;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_SETTLE;
          cnt_next   = '0;
          vec_next   = 4'd0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          err_next   = 5'd0;
          ff_next    = 4'd0;
          ffv_next   = 1'b0;
        end
      end

      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_next = S_CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_next = err_count + 5'd1;
          if (!first_fail_vld) begin
            ff_next  = vec_out;
            ffv_next = 1'b1;
          end
        end
        // vec_out never wraps inside a sweep; it holds on the last vector checked
        if ((vec_out == 4'd15) || stop_now) begin
          state_next = S_DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = S_SETTLE;
          vec_next   = vec_out + 4'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_myfunc_sweeper.sv
// Testbench for myfunc_sweeper: directed sweeps with hand-computed results,
// checked by a scoreboard monitor that fires on each rising edge of done.
module tb_myfunc_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic       f1, f3;
  logic [2:0] mode;

  logic [3:0] vec1, vec3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [4:0] err1, err3;
  logic [3:0] ff1, ff3;
  logic       ffv1, ffv3;

  myfunc_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .first_fail_vld(ffv1)
  );

  myfunc_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3), .first_fail_vld(ffv3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Function-under-test models: 0 correct, 1 tied 0, 2 inverted,
  // 3 corrupted at vector 6, other tied 1
  function automatic logic model(input logic [2:0] md, input logic [3:0] v);
    logic [15:0] g;
    g = 16'hF051;
    case (md)
      3'd0:    return g[v];
      3'd1:    return 1'b0;
      3'd2:    return ~g[v];
      3'd3:    return g[v] ^ (v == 4'd6);
      default: return 1'b1;
    endcase
  endfunction

  always_comb f1 = model(mode, vec1);
  always_comb f3 = model(mode, vec3);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int    which;
    int    t0;
    int    lat;
    int    err;
    int    ff;
    int    ffv;
    int    vec;
    int    pss;
    string tag;
  } exp_t;

  exp_t sb[$];

  // Scoreboard monitor: compare on every rising edge of the selected done
  exp_t e;
  logic pd1 = 1'b0;
  logic pd3 = 1'b0;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb[0];
      if ((e.which == 1) ? (done1 && !pd1) : (done3 && !pd3)) begin
        e = sb.pop_front();
        chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
        if (e.which == 1) begin
          chk({e.tag, "_err"},  int'(err1), e.err);
          chk({e.tag, "_ff"},   int'(ff1),  e.ff);
          chk({e.tag, "_ffv"},  int'(ffv1), e.ffv);
          chk({e.tag, "_vec"},  int'(vec1), e.vec);
          chk({e.tag, "_pass"}, int'(pass1), e.pss);
          chk({e.tag, "_busy"}, int'(busy1), 0);
        end else begin
          chk({e.tag, "_err"},  int'(err3), e.err);
          chk({e.tag, "_ff"},   int'(ff3),  e.ff);
          chk({e.tag, "_ffv"},  int'(ffv3), e.ffv);
          chk({e.tag, "_vec"},  int'(vec3), e.vec);
          chk({e.tag, "_pass"}, int'(pass3), e.pss);
          chk({e.tag, "_busy"}, int'(busy3), 0);
        end
      end
    end
    pd1 = done1;
    pd3 = done3;
  end

  // Issue one sweep, queue its expected result and wait for the monitor
  task automatic run(input int which, input logic [2:0] md, input int lat,
                     input int err, input int ff, input int ffv, input int vec,
                     input int pss, input string tag);
    exp_t x;
    @(negedge clk);
    mode = md;
    x.which = which; x.t0 = cyc + 1; x.lat = lat; x.err = err; x.ff = ff;
    x.ffv = ffv; x.vec = vec; x.pss = pss; x.tag = tag;
    sb.push_back(x);
    if (which == 1) start1 = 1'b1;
    else            start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    // One cycle after accept: busy up, done down, counters cleared
    chk({tag, "_acc_busy"}, int'((which == 1) ? busy1 : busy3), 1);
    chk({tag, "_acc_done"}, int'((which == 1) ? done1 : done3), 0);
    chk({tag, "_acc_err"},  int'((which == 1) ? err1 : err3), 0);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done never rose, queued %0d want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  int t0;

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode   = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_vec",  int'(vec1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err",  int'(err1), 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef MYFUNC_SWEEP_STOP_ON_FAIL_EN
    run(1, 3'd0, 32, 0,  0, 0, 15, 1, "good");
    run(1, 3'd1,  2, 1,  0, 1,  0, 0, "tied0");
    run(1, 3'd2,  2, 1,  0, 1,  0, 0, "inv");
    run(3, 3'd3, 28, 1,  6, 1,  6, 0, "bad6");
    run(1, 3'd4,  4, 1,  1, 1,  1, 0, "tied1");
`else
    run(1, 3'd0, 32, 0,  0, 0, 15, 1, "good");
    run(1, 3'd1, 32, 7,  0, 1, 15, 0, "tied0");
    run(1, 3'd2, 32, 16, 0, 1, 15, 0, "inv");
    run(3, 3'd3, 64, 1,  6, 1, 15, 0, "bad6");
    run(1, 3'd4, 32, 9,  1, 1, 15, 0, "tied1");
`endif

    // Restart attempt while busy is ignored; reset aborts at vector 9
    @(negedge clk);
    mode   = 3'd0;
    t0     = cyc + 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vec1 == 4'd3) break;
      @(negedge clk);
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vec1 == 4'd9) break;
      @(negedge clk);
    end
    chk("abort_vec9_time", cyc - t0, 18);
    chk("abort_busy_pre", int'(busy1), 1);
    rst = 1'b1;
    #1;
    chk("abort_vec",  int'(vec1), 0);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    chk("abort_pass", int'(pass1), 0);
    chk("abort_err",  int'(err1), 0);
    chk("abort_ff",   int'(ff1), 0);
    chk("abort_ffv",  int'(ffv1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(busy1), 0);
    chk("idle_done", int'(done1), 0);
    chk("idle_vec",  int'(vec1), 0);

    run(1, 3'd0, 32, 0, 0, 0, 15, 1, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
